iob_wb2iob_bridge: RTL and testbench

Wishbone B4 classic slave to IOb master bridge with write posting, for the Ethernet MAC DMA master port and other Wishbone masters feeding IOb memory.
- Successor to the single-transaction wishbone-to-IOb path, parametrised in address/data width and posting depth.
- Writes are acknowledged once queued, so the MAC does not stall on memory latency.
- Reads are strictly ordered behind posted writes.
- A watchdog is optional (see Optional Feature).

---
 rtl/iob_wb2iob_bridge_pkg.sv | 26 ++
 rtl/iob_wb2iob_bridge_fifo.sv | 56 +++++
 rtl/iob_wb2iob_bridge.sv | 187 ++++++++++++++++++
 tb/tb_iob_wb2iob_bridge.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_wb2iob_bridge_pkg.sv
// rtl/iob_wb2iob_bridge_pkg.sv - master FSM states and posted-write FIFO entry layout
package iob_wb2iob_bridge_pkg;

  // IOb master FSM states
  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } m_state_t;

  // FIFO entry layout, LSB first: sel, then dat, then adr
  localparam int SEL_LSB = 0;

  function automatic int dat_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int adr_lsb(input int data_w);
    return data_w / 8 + data_w;
  endfunction

  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_wb2iob_bridge_fifo.sv
// rtl/iob_wb2iob_bridge_fifo.sv - iob_sync_fifo, synchronous FIFO holding posted writes
module iob_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   DEPTH = (AW+1)'(1) << AW;
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // full/empty come from the registered level, so a pop only frees a slot next cycle
  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // storage write; contents need no reset because level gates every use of head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointer and occupancy bookkeeping; pointers wrap modulo the depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iob_wb2iob_bridge.sv
// rtl/iob_wb2iob_bridge.sv - Wishbone classic slave to IOb master bridge with posted writes (optional watchdog: IOB_WB2IOB_TIMEOUT_EN)
module iob_wb2iob_bridge
  import iob_wb2iob_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIFO_AW   = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic [FIFO_AW:0]    fifo_level_o,
  output logic                wr_drop_o
);

  localparam int SEL_W   = DATA_W / 8;
  localparam int ENT_W   = entry_w(ADDR_W, DATA_W);
  localparam int DAT_LSB = dat_lsb(DATA_W);
  localparam int ADR_LSB = adr_lsb(DATA_W);

  m_state_t           state_q;
  m_state_t           state_d;
  logic               acc;
  logic               wr_acc;
  logic               rd_acc;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               tmo_hit;
  logic [ENT_W-1:0]   push_data;
  logic [ENT_W-1:0]   head;
  logic               m_valid_d;
  logic [ADDR_W-1:0]  m_addr_d;
  logic [DATA_W-1:0]  m_wdata_d;
  logic [SEL_W-1:0]   m_wstrb_d;
  logic [DATA_W-1:0]  dat_d;
  logic               ack_d;

  // the registered ack/err pulse masks the strobe that caused it
  assign acc       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr_acc    = acc & wb_we_i & ~fifo_full;
  assign rd_acc    = acc & ~wb_we_i & fifo_empty & (state_q == M_IDLE);
  assign push_data = {wb_adr_i, wb_dat_i, wb_sel_i};

  iob_sync_fifo #(
    .W  (ENT_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_acc),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

`ifdef IOB_WB2IOB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err_q;
  logic                 drop_q;

  assign tmo_hit   = m_valid & ~m_ready & (&tmo_cnt);
  assign wb_err_o  = err_q;
  assign wr_drop_o = drop_q;

  // stall counter: runs while a request waits, restarts on completion, abort or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == M_IDLE || m_ready || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  // abort pulses: error back to a waiting reader, drop notice for a discarded write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      err_q  <= tmo_hit & (state_q == M_READ) & wb_cyc_i;
      drop_q <= tmo_hit & (state_q == M_WRITE);
    end
  end
`else
  logic [TIMEOUT_W-1:0] unused_tmo_w;

  assign unused_tmo_w = '0;
  assign tmo_hit      = 1'b0;
  assign wb_err_o     = 1'b0;
  assign wr_drop_o    = 1'b0;
`endif

  // master FSM next state and next values of the registered IOb/WB outputs
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    m_wstrb_d = m_wstrb;
    dat_d     = wb_dat_o;
    pop       = 1'b0;
    ack_d     = wr_acc;
    case (state_q)
      M_IDLE: begin
        if (!fifo_empty) begin
          state_d   = M_WRITE;
          m_valid_d = 1'b1;
          m_addr_d  = head[ADR_LSB +: ADDR_W];
          m_wdata_d = head[DAT_LSB +: DATA_W];
          m_wstrb_d = head[SEL_LSB +: SEL_W];
        end else if (rd_acc) begin
          state_d   = M_READ;
          m_valid_d = 1'b1;
          m_addr_d  = wb_adr_i;
          m_wstrb_d = '0;
        end
      end
      M_WRITE: begin
        if (m_ready || tmo_hit) begin
          pop       = 1'b1;
          m_valid_d = 1'b0;
          state_d   = M_IDLE;
        end
      end
      M_READ: begin
        if (m_ready) begin
          dat_d     = m_rdata;
          ack_d     = wr_acc | wb_cyc_i;
          m_valid_d = 1'b0;
          state_d   = M_IDLE;
        end else if (tmo_hit) begin
          m_valid_d = 1'b0;
          state_d   = M_IDLE;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = M_IDLE;
      end
    endcase
  end

  // state and output registers; reset drops m_valid at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= M_IDLE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_valid  <= m_valid_d;
      m_addr   <= m_addr_d;
      m_wdata  <= m_wdata_d;
      m_wstrb  <= m_wstrb_d;
      wb_dat_o <= dat_d;
      wb_ack_o <= ack_d;
    end
  end

endmodule

// File: tb/tb_iob_wb2iob_bridge.sv
// tb/tb_iob_wb2iob_bridge.sv - directed and randomized bench for iob_wb2iob_bridge
module tb_iob_wb2iob_bridge;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic [2:0]  level;
  logic        wr_drop;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;
  int          ready_mode = 1;
  logic [31:0] rd_value = '0;
  bit          mon_on = 0;
  int          rd_hs_cnt = 0;
  int          rd_hs_cyc = -1;
  int          wr_at_rd = -1;
  wr_t         exp_q[$];
  wr_t         got_q[$];

  always #5 clk = ~clk;

  iob_wb2iob_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_adr_i     (wb_adr),
    .wb_sel_i     (wb_sel),
    .wb_we_i      (wb_we),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_dat_i     (wb_dat_w),
    .wb_dat_o     (wb_dat_r),
    .wb_ack_o     (wb_ack),
    .wb_err_o     (wb_err),
    .m_valid      (m_valid),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_rdata      (m_rdata),
    .m_ready      (m_ready),
    .fifo_level_o (level),
    .wr_drop_o    (wr_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // IOb memory side: ready policy and read data applied just after each rising edge
  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      m_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      m_rdata = rd_value;
    end
  end

  // IOb monitor: collects the completed write stream and checks request stability
  initial begin
    logic        pv, pr;
    logic [31:0] pa, pd;
    logic [3:0]  ps;
    wr_t         e;
    pv = 0; pr = 0; pa = '0; pd = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (pv && !pr) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_addr", m_addr, pa);
          chk("hold_wdata", m_wdata, pd);
          chk("hold_wstrb", m_wstrb, ps);
        end
        if (pv && pr) chk("gap_valid", m_valid, 0);
      end
      if (m_valid && m_ready) begin
        if (m_wstrb != 4'h0) begin
          e.a = m_addr; e.d = m_wdata; e.s = m_wstrb;
          got_q.push_back(e);
        end else begin
          rd_hs_cnt++;
          rd_hs_cyc = cyc_cnt;
          wr_at_rd  = got_q.size();
        end
      end
      pv = m_valid; pr = m_ready; pa = m_addr; pd = m_wdata; ps = m_wstrb;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wb_idle();
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int budget, output bit acked, output int lat);
    wr_t e;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = a; wb_dat_w = d; wb_sel = s;
    acked = 0; lat = 0;
    while (!acked && lat < budget) begin
      @(negedge clk);
      lat++;
      if (wb_ack) begin
        acked = 1;
        e.a = a; e.d = d; e.s = s;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wb_read(input logic [31:0] a, input int budget, output bit acked, output bit errd,
                         output int lat);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = a; wb_sel = 4'hF;
    acked = 0; errd = 0; lat = 0;
    while (!acked && !errd && lat < budget) begin
      @(negedge clk);
      lat++;
      acked = wb_ack;
      errd  = wb_err;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (level == 0) && !m_valid;
    end
    chk({tag, "_drained"}, done, 1);
  endtask

  task automatic check_stream(input string tag);
    wr_t g, x;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_addr"}, g.a, x.a);
      chk({tag, "_data"}, g.d, x.d);
      chk({tag, "_strb"}, g.s, x.s);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit          acked, errd, seen_ack, seen_valid;
    int          lat, rd0;
    logic [31:0] a5, d5, rv;

    rst_n = 0;
    wb_adr = '0; wb_sel = '0; wb_dat_w = '0;
    wb_idle();
    repeat (3) @(negedge clk);
    chk("reset_ack", wb_ack, 0);
    chk("reset_err", wb_err, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_addr", m_addr, 0);
    chk("reset_wdata", m_wdata, 0);
    chk("reset_wstrb", m_wstrb, 0);
    chk("reset_rdata", wb_dat_r, 0);
    chk("reset_level", level, 0);
    chk("reset_drop", wr_drop, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    mon_on = 1;

    // single posted write with zero-wait memory
    wb_write(32'h100, 32'hDEADBEEF, 4'hF, 20, acked, lat);
    wb_idle();
    chk("t1_ack", acked, 1);
    chk("t1_ack_lat", lat, 1);
    chk("t1_valid_before", m_valid, 0);
    chk("t1_level_pushed", level, 1);
    @(negedge clk);
    chk("t1_valid", m_valid, 1);
    chk("t1_addr", m_addr, 32'h100);
    chk("t1_wdata", m_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", m_wstrb, 4'hF);
    @(negedge clk);
    chk("t1_level_done", level, 0);
    chk("t1_valid_drop", m_valid, 0);
    check_stream("t1");

    // six writes against a stalled memory: four fill the FIFO, the fifth waits
    ready_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h1000 + 32'(i * 4), $urandom, 4'hF, 5, acked, lat);
      chk("t2_fill_ack", acked, 1);
    end
    a5 = 32'h1010; d5 = $urandom;
    wb_write(a5, d5, 4'h3, 20, acked, lat);
    chk("t2_full_noack", acked, 0);
    chk("t2_full_level", level, 4);
    ready_mode = 1;
    wb_write(a5, d5, 4'h3, 20, acked, lat);
    chk("t2_ack5", acked, 1);
    chk("t2_ack5_level", level, 4);
    wb_write(32'h1014, $urandom, 4'hC, 20, acked, lat);
    chk("t2_ack6", acked, 1);
    chk("t2_ack6_level", level, 4);
    wb_idle();
    wait_drain("t2", 100);
    check_stream("t2");

    // read is held behind a pending posted write
    ready_mode = 0;
    repeat (2) @(negedge clk);
    wb_write(32'h200, 32'hCAFEF00D, 4'hF, 5, acked, lat);
    chk("t3_wr_ack", acked, 1);
    rd_value = 32'h12345678;
    rd0 = rd_hs_cnt;
    wb_read(32'h200, 10, acked, errd, lat);
    chk("t3_rd_blocked", acked, 0);
    chk("t3_no_rd_issue", rd_hs_cnt, rd0);
    chk("t3_iob_write_valid", m_valid, 1);
    chk("t3_iob_write_strb", m_wstrb, 4'hF);
    ready_mode = 1;
    wb_read(32'h200, 30, acked, errd, lat);
    wb_idle();
    chk("t3_rd_ack", acked, 1);
    chk("t3_rd_data", wb_dat_r, 32'h12345678);
    chk("t3_ack_after_hs", cyc_cnt, rd_hs_cyc + 1);
    chk("t3_write_first", wr_at_rd, 1);
    check_stream("t3");

    // reset while a read is outstanding and three writes are posted
    ready_mode = 0;
    repeat (2) @(negedge clk);
    wb_read(32'h300, 3, acked, errd, lat);
    chk("t4_rd_pending", acked, 0);
    wb_idle();
    @(negedge clk);
    chk("t4_in_read_valid", m_valid, 1);
    chk("t4_in_read_strb", m_wstrb, 0);
    for (int i = 0; i < 3; i++) begin
      wb_write(32'h400 + 32'(i * 4), $urandom, 4'hF, 5, acked, lat);
      chk("t4_wr_ack", acked, 1);
    end
    wb_idle();
    @(negedge clk);
    chk("t4_level3", level, 3);
    mon_on = 0;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("t4_rst_valid", m_valid, 0);
    chk("t4_rst_level", level, 0);
    chk("t4_rst_ack", wb_ack, 0);
    @(negedge clk);
    rst_n = 1;
    ready_mode = 1;
    got_q.delete();
    exp_q.delete();
    seen_ack = 0; seen_valid = 0;
    repeat (10) begin
      @(negedge clk);
      seen_ack   = seen_ack | wb_ack;
      seen_valid = seen_valid | m_valid;
    end
    chk("t4_no_ack", seen_ack, 0);
    chk("t4_no_issue", seen_valid, 0);
    chk("t4_no_writes", got_q.size(), 0);
    mon_on = 1;

    // cyc dropped during a read: the IOb read completes, no ack reaches the master
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rd_value = 32'hA5A50F0F;
    rd0 = rd_hs_cnt;
    wb_read(32'h500, 3, acked, errd, lat);
    wb_idle();
    ready_mode = 1;
    seen_ack = 0;
    repeat (6) begin
      @(negedge clk);
      seen_ack = seen_ack | wb_ack;
    end
    chk("t5_no_ack", seen_ack, 0);
    chk("t5_rd_done", rd_hs_cnt, rd0 + 1);
    chk("t5_rd_data", wb_dat_r, 32'hA5A50F0F);

`ifdef IOB_WB2IOB_TIMEOUT_EN
    // watchdog aborts a stuck read and discards a stuck posted write
    mon_on = 0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    wb_read(32'h600, 1000, acked, errd, lat);
    wb_idle();
    chk("tmo_rd_err", errd, 1);
    chk("tmo_rd_noack", acked, 0);
    @(negedge clk);
    chk("tmo_rd_valid_drop", m_valid, 0);
    wb_write(32'h700, 32'h0BADF00D, 4'hF, 5, acked, lat);
    wb_idle();
    chk("tmo_wr_ack", acked, 1);
    seen_ack = 0;
    for (int i = 0; i < 1000 && !seen_ack; i++) begin
      @(negedge clk);
      seen_ack = wr_drop;
    end
    chk("tmo_wr_drop", seen_ack, 1);
    chk("tmo_wr_level", level, 0);
    ready_mode = 1;
    repeat (3) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    mon_on = 1;
`else
    // without the watchdog a stuck read just waits
    ready_mode = 0;
    repeat (2) @(negedge clk);
    wb_read(32'h600, 40, acked, errd, lat);
    wb_idle();
    chk("nwd_no_err", errd, 0);
    chk("nwd_no_ack", acked, 0);
    chk("nwd_waiting", m_valid, 1);
    chk("nwd_no_drop", wr_drop, 0);
    ready_mode = 1;
    repeat (4) @(negedge clk);
`endif

    // random back-to-back traffic against a randomly stalling memory
    ready_mode = 2;
    rv = '0;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        rv = $urandom;
        rd_value = rv;
        wb_read($urandom, 200, acked, errd, lat);
        chk("t6_rd_ack", acked, 1);
        chk("t6_rd_data", wb_dat_r, rv);
      end else begin
        wb_write($urandom, $urandom, 4'($urandom_range(1, 15)), 200, acked, lat);
        chk("t6_wr_ack", acked, 1);
      end
    end
    wb_idle();
    wait_drain("t6", 200);
    check_stream("t6");
    chk("t6_rdata_hold", wb_dat_r, rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
